// File: rtl/bus_pkg.sv
// bus_pkg: shared bus constants and field widths for bus-attached devices
package bus_pkg;

    // Default packet width in bits
    localparam int PCKG_SZ = 16;

    // Width of the destination ID field at the top of every packet
    localparam int ID_W = 8;

    // Destination ID accepted by every device on the bus
    localparam logic [ID_W-1:0] BROADCAST = 8'hFF;

    typedef logic [ID_W-1:0] dev_id_t;

endpackage

// File: rtl/dev_fifo.sv
// dev_fifo: synchronous first-word-fall-through FIFO; head is 0 while empty
module dev_fifo #(
    parameter int width = 16,
    parameter int depth = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [width-1:0] din,
    output logic [width-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PW = (depth > 1) ? $clog2(depth) : 1;
    localparam int CW = $clog2(depth + 1);

    logic [width-1:0] mem [depth];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    // A pop on an empty FIFO is ignored; a push into a full FIFO only
    // lands when a pop frees the head slot in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = count == CW'(depth);
    assign empty   = count == '0;
    assign dout    = empty ? '0 : mem[rd_ptr];

    // Storage write; pointers are cleared by reset so stale data is harmless
    always_ff @(posedge clk) begin
        if (!reset && do_push)
            mem[wr_ptr] <= din;
    end

    // Pointers wrap modulo depth and the occupancy counter spans 0..depth
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= (wr_ptr == PW'(depth - 1)) ? '0 : wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= (rd_ptr == PW'(depth - 1)) ? '0 : rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/bus_device_port.sv
// bus_device_port: host/bus device port with TX and RX FIFOs and an address filter
module bus_device_port
    import bus_pkg::*;
#(
    parameter int      pckg_sz   = PCKG_SZ,
    parameter int      fifo_size = 8,
    parameter dev_id_t id        = '0,
    parameter dev_id_t broadcast = BROADCAST
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [pckg_sz-1:0] wr_data,
    output logic               tx_full,
    output logic               pndng,
    output logic [pckg_sz-1:0] D_pop,
    input  logic               pop,
    input  logic               push,
    input  logic [pckg_sz-1:0] D_push,
    input  logic               rd_en,
    output logic [pckg_sz-1:0] rd_data,
    output logic               rx_valid,
    output logic               tx_ovf,
    output logic               rx_ovf,
    output logic [7:0]         drop_cnt
);

    dev_id_t dest;
    logic    match;
    logic    rx_full;
    logic    tx_empty;
    logic    rx_empty;

    assign dest     = D_push[pckg_sz-1 -: ID_W];
    assign match    = (dest == id) || (dest == broadcast);
    assign pndng    = !tx_empty;
    assign rx_valid = !rx_empty;

    dev_fifo #(.width(pckg_sz), .depth(fifo_size)) u_tx (
        .clk   (clk),
        .reset (reset),
        .push  (wr_en),
        .pop   (pop),
        .din   (wr_data),
        .dout  (D_pop),
        .full  (tx_full),
        .empty (tx_empty)
    );

    dev_fifo #(.width(pckg_sz), .depth(fifo_size)) u_rx (
        .clk   (clk),
        .reset (reset),
        .push  (push && match),
        .pop   (rd_en),
        .din   (D_push),
        .dout  (rd_data),
        .full  (rx_full),
        .empty (rx_empty)
    );

    // Sticky overflow flags: set when a write is lost because nothing drains the full FIFO
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_ovf <= 1'b0;
            rx_ovf <= 1'b0;
        end else begin
            if (wr_en && tx_full && !pop)
                tx_ovf <= 1'b1;
            if (push && match && rx_full && !rd_en)
                rx_ovf <= 1'b1;
        end
    end

    // Count misaddressed pushes, holding at 255
    always_ff @(posedge clk) begin
        if (reset)
            drop_cnt <= '0;
        else if (push && !match && drop_cnt != 8'hFF)
            drop_cnt <= drop_cnt + 8'd1;
    end

endmodule
